apb_master_arb: RTL and testbench
=================================

// Module: apb_master_arb
// PURPOSE
//  APB3 master that shares one APB slave port (e.g. gpio_slave) between two requesters.
//  Round-robin arbitration; drives the IDLE->SETUP->ACCESS sequence and waits on PREADY.
//  Returns read data and error to the granted requester; aborts hung transfers by timeout.
// PARAMETERS
//  ADDR_WIDTH      32  width of PADDR and per-requester address
//  DATA_WIDTH      32  width of PWDATA/PRDATA
//  TIMEOUT_CYCLES  16  max ACCESS cycles waiting for PREADY; 0 = no timeout
// PORTS
//  PCLK        in   1               clock, all state updates on rising edge
//  PRESET      in   1               asynchronous reset, active-high
//  req_valid   in   2               request pending, bit i = requester i
//  req_write   in   2               1 = write, 0 = read, per requester
//  req_addr    in   2*ADDR_WIDTH    requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata   in   2*DATA_WIDTH    requester i write data, same packing
//  resp_done   out  2               1-cycle completion pulse to requester i
//  resp_err    out  1               error for the completing transfer (valid with resp_done)
//  resp_rdata  out  DATA_WIDTH      read data for the completing transfer (valid with resp_done)
//  busy        out  1               high while in SETUP or ACCESS
//  PADDR       out  ADDR_WIDTH      APB address
//  PSELx       out  1               APB slave select
//  PENABLE     out  1               APB access phase
//  PWRITE      out  1               APB direction
//  PWDATA      out  DATA_WIDTH      APB write data, 0 for reads
//  PREADY      in   1               slave ready
//  PRDATA      in   DATA_WIDTH      slave read data
//  PSLVERR     in   1               slave error, sampled only with PREADY
// BEHAVIOUR
//  Reset (async, PRESET=1): state IDLE, all outputs 0, RR pointer = requester 0, timeout counter 0.
//   Reset mid-transfer drops PSELx/PENABLE immediately; no resp_done issued for the aborted transfer.
//  FSM states: IDLE, SETUP, ACCESS. All outputs registered.
//  IDLE: eligible_i = req_valid[i] & ~resp_done[i] (a requester is not re-granted in its done cycle).
//   None eligible -> stay IDLE. One eligible -> grant it. Both -> grant the RR pointer's requester.
//   On grant: latch addr/wdata/write into PADDR/PWDATA/PWRITE, PSELx=1, PENABLE=0, go SETUP,
//   move RR pointer to the other requester.
//  SETUP: exactly 1 cycle; next edge sets PENABLE=1 and goes ACCESS. The counter clears.
//  ACCESS: PADDR/PWDATA/PWRITE/PSELx held stable.
//   PREADY=1: PSELx=0, PENABLE=0, resp_done[grant]=1, resp_err=PSLVERR,
//    resp_rdata=PRDATA on reads (0 on writes), go IDLE.
//   PREADY=0: counter+1. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES:
//    same exit as above, but resp_err=1 and resp_rdata=0.
//  resp_done/resp_err/resp_rdata are valid for one cycle only (the IDLE cycle after completion).
//   resp_err and resp_rdata are 0 otherwise.
//  Latency: grant edge -> SETUP (1) -> ACCESS (>=1) -> done; zero-wait transfer = 3 edges from grant.
//   Minimum issue spacing is 3 cycles (IDLE, SETUP, ACCESS).
//  Requesters hold req_* stable until resp_done; a req_valid drop mid-transfer is ignored.
//  PWDATA=0 whenever PWRITE=0.
// TESTING
//  1 Req0 write addr 0x4, data 0xDEADBEEF, PREADY=1 in ACCESS -> PSELx 2 cycles, PENABLE 1 cycle,
//    resp_done=2'b01, resp_err=0.
//  2 Req1 read addr 0x4 after test 1 -> resp_rdata=0xDEADBEEF, resp_done=2'b10.
//  3 Both req_valid held continuously -> grants alternate 0,1,0,1, with no back-to-back grant
//    to the same requester.
//  4 PREADY held low 3 ACCESS cycles, then high with PSLVERR=1 -> PADDR/PWDATA stable throughout,
//    resp_err=1.
//  5 PREADY never asserted, TIMEOUT_CYCLES=16 -> exit after 16 ACCESS cycles,
//    resp_err=1, resp_rdata=0, busy=0.
//  6 PRESET asserted during ACCESS -> PSELx=PENABLE=0 same cycle, no resp_done; after release,
//    a pending req1 with req0 idle -> req1 granted.

Source files
------------

// File: rtl/apb_master_arb.sv
// APB3 master shared by two requesters with round-robin arbitration.
// Runs the IDLE->SETUP->ACCESS sequence, returns read data/error and aborts hung transfers by timeout.
module apb_master_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              resp_done,
  output logic                    resp_err,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  // Handshake: requester i raises req_valid[i] and holds req_* stable until the
  // single-cycle resp_done[i] pulse; resp_err/resp_rdata are meaningful only in that cycle.

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW:0] TO_LIM = (CW+1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                  state, state_nxt;
  logic                    rr_ptr, rr_nxt;
  logic                    gnt, gnt_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [CW:0]             cnt_inc;
  logic [1:0]              elig;
  logic                    sel;
  logic [ADDR_WIDTH-1:0]   paddr_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt;
  logic                    pwrite_nxt, psel_nxt, pen_nxt, busy_nxt;
  logic [1:0]              done_nxt;
  logic                    err_nxt;
  logic [DATA_WIDTH-1:0]   rdata_nxt;
  logic                    timed_out;

  assign elig      = req_valid & ~resp_done;
  assign sel       = (elig == 2'b11) ? rr_ptr : elig[1];
  assign cnt_inc   = {1'b0, cnt} + (CW+1)'(1);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    gnt_nxt    = gnt;
    cnt_nxt    = cnt;
    paddr_nxt  = PADDR;
    pwdata_nxt = PWDATA;
    pwrite_nxt = PWRITE;
    psel_nxt   = PSELx;
    pen_nxt    = PENABLE;
    busy_nxt   = busy;
    done_nxt   = 2'b00;
    err_nxt    = 1'b0;
    rdata_nxt  = '0;
    case (state)
      S_IDLE: begin
        if (|elig) begin
          gnt_nxt    = sel;
          rr_nxt     = ~sel;
          paddr_nxt  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          pwrite_nxt = req_write[sel];
          // Write data is forced to zero for reads so PWDATA never leaks a stale value.
          pwdata_nxt = !req_write[sel] ? '0 :
                       (sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0]);
          psel_nxt   = 1'b1;
          pen_nxt    = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        pen_nxt   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY || timed_out) begin
          psel_nxt  = 1'b0;
          pen_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = gnt ? 2'b10 : 2'b01;
          state_nxt = S_IDLE;
          if (PREADY) begin
            err_nxt   = PSLVERR;
            rdata_nxt = PWRITE ? '0 : PRDATA;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_inc[CW-1:0];
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      gnt        <= 1'b0;
      cnt        <= '0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PWRITE     <= 1'b0;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
      busy       <= 1'b0;
      resp_done  <= 2'b00;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      gnt        <= gnt_nxt;
      cnt        <= cnt_nxt;
      PADDR      <= paddr_nxt;
      PWDATA     <= pwdata_nxt;
      PWRITE     <= pwrite_nxt;
      PSELx      <= psel_nxt;
      PENABLE    <= pen_nxt;
      busy       <= busy_nxt;
      resp_done  <= done_nxt;
      resp_err   <= err_nxt;
      resp_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: a small APB slave model driven from the transfer
// wait loop, hand-computed expectations and a grant-order queue.
module tb_apb_master_arb;

  logic        PCLK, PRESET;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  resp_done;
  logic        resp_err, busy;
  logic [31:0] resp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;

  apb_master_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_err(resp_err), .resp_rdata(resp_rdata), .busy(busy),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0]  exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic        slv_err = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for one transfer to complete, acting as the APB slave while it runs.
  // ready_delay < 0 means PREADY is never asserted.
  task automatic wait_done(input int ready_delay, input int budget,
                           output logic [1:0] done, output logic err, output logic [31:0] rdata,
                           output int sel_cyc, output int en_cyc, output int unstable,
                           output logic [31:0] s_addr, output logic [31:0] s_wdata,
                           output logic [2:0] bus_at_done, output bit to);
    int  acc = 0;
    bit  seen = 0;
    done = '0; err = 1'b0; rdata = '0; sel_cyc = 0; en_cyc = 0; unstable = 0;
    s_addr = '0; s_wdata = '0; bus_at_done = '0; to = 1'b1;
    PREADY = 1'b0; PSLVERR = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge PCLK);
      if (resp_done != 2'b00) begin
        done = resp_done; err = resp_err; rdata = resp_rdata;
        bus_at_done = {busy, PSELx, PENABLE};
        PREADY = 1'b0; PSLVERR = 1'b0;
        to = 1'b0;
        return;
      end
      if (PSELx) begin
        sel_cyc++;
        if (!seen) begin
          seen = 1'b1; s_addr = PADDR; s_wdata = PWDATA;
        end else if (PADDR !== s_addr || PWDATA !== s_wdata) begin
          unstable++;
        end
      end
      if (PENABLE) en_cyc++;
      if (PSELx && PENABLE) begin
        acc++;
        PREADY  = (ready_delay >= 0) && (acc > ready_delay);
        PSLVERR = PREADY ? slv_err : 1'b0;
        if (PREADY && PWRITE) mem[PADDR] = PWDATA;
      end else begin
        PREADY = 1'b0;
      end
      PRDATA = mem.exists(PADDR) ? mem[PADDR] : 32'h0;
    end
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1);
    req_valid = v; req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  logic [1:0]  done;
  logic        err;
  logic [31:0] rdata, s_addr, s_wdata;
  logic [2:0]  bus;
  int          sel_cyc, en_cyc, unstable, done_in_rst;
  bit          to, hit;

  initial begin
    PRESET = 1'b1; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    set_req(2'b00, 2'b00, 0, 0, 0, 0);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_psel",   PSELx, 0);
    check_eq("rst_pen",    PENABLE, 0);
    check_eq("rst_busy",   busy, 0);
    check_eq("rst_done",   resp_done, 0);
    check_eq("rst_paddr",  PADDR, 0);
    check_eq("rst_pwdata", PWDATA, 0);

    // 1: req0 write, zero wait
    set_req(2'b01, 2'b01, 32'h4, 32'hDEADBEEF, 32'h0, 32'h0);
    wait_done(0, 40, done, err, rdata, sel_cyc, en_cyc, unstable, s_addr, s_wdata, bus, to);
    check_eq("t1_timeout", to, 0);
    check_eq("t1_done", done, 2'b01);
    check_eq("t1_err", err, 0);
    check_eq("t1_psel_cyc", sel_cyc, 2);
    check_eq("t1_pen_cyc", en_cyc, 1);
    check_eq("t1_paddr", s_addr, 32'h4);
    check_eq("t1_pwdata", s_wdata, 32'hDEADBEEF);
    check_eq("t1_bus_idle", bus, 0);

    // 2: req1 reads back
    set_req(2'b10, 2'b00, 32'h0, 32'h0, 32'h4, 32'h12345678);
    wait_done(0, 40, done, err, rdata, sel_cyc, en_cyc, unstable, s_addr, s_wdata, bus, to);
    check_eq("t2_timeout", to, 0);
    check_eq("t2_done", done, 2'b10);
    check_eq("t2_rdata", rdata, 32'hDEADBEEF);
    check_eq("t2_pwdata_rd", s_wdata, 0);
    check_eq("t2_err", err, 0);

    // 3: both requesting continuously -> alternating grants
    set_req(2'b11, 2'b11, 32'h10, 32'h1111, 32'h20, 32'h2222);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_done(0, 40, done, err, rdata, sel_cyc, en_cyc, unstable, s_addr, s_wdata, bus, to);
      check_eq("t3_timeout", to, 0);
      check_eq("t3_grant", done, exp_q.pop_front());
      check_eq("t3_addr", s_addr, (done == 2'b01) ? 32'h10 : 32'h20);
    end

    // 4: 3 wait states then PSLVERR
    slv_err = 1'b1;
    set_req(2'b01, 2'b01, 32'h8, 32'hA5A50001, 32'h0, 32'h0);
    wait_done(3, 40, done, err, rdata, sel_cyc, en_cyc, unstable, s_addr, s_wdata, bus, to);
    slv_err = 1'b0;
    check_eq("t4_timeout", to, 0);
    check_eq("t4_done", done, 2'b01);
    check_eq("t4_err", err, 1);
    check_eq("t4_stable", unstable, 0);
    check_eq("t4_pen_cyc", en_cyc, 4);
    check_eq("t4_pwdata", s_wdata, 32'hA5A50001);

    // 5: slave never ready -> timeout after 16 ACCESS cycles
    set_req(2'b10, 2'b00, 32'h0, 32'h0, 32'h4, 32'h0);
    wait_done(-1, 60, done, err, rdata, sel_cyc, en_cyc, unstable, s_addr, s_wdata, bus, to);
    check_eq("t5_timeout", to, 0);
    check_eq("t5_done", done, 2'b10);
    check_eq("t5_err", err, 1);
    check_eq("t5_rdata", rdata, 0);
    check_eq("t5_pen_cyc", en_cyc, 16);
    check_eq("t5_bus_idle", bus, 0);

    // 6: reset during ACCESS, then a lone req1 is served
    set_req(2'b01, 2'b01, 32'hC, 32'h00000BAD, 32'h0, 32'h0);
    PREADY = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge PCLK);
      hit = PSELx && PENABLE;
    end
    check_eq("t6_reach_access", hit, 1);
    PRESET = 1'b1;
    set_req(2'b10, 2'b00, 32'h0, 32'h0, 32'h4, 32'h0);
    #1;
    check_eq("t6_rst_psel", PSELx, 0);
    check_eq("t6_rst_pen", PENABLE, 0);
    done_in_rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      if (resp_done != 2'b00) done_in_rst++;
    end
    PRESET = 1'b0;
    @(negedge PCLK);
    if (resp_done != 2'b00) done_in_rst++;
    check_eq("t6_no_done", done_in_rst, 0);
    wait_done(0, 40, done, err, rdata, sel_cyc, en_cyc, unstable, s_addr, s_wdata, bus, to);
    check_eq("t6_timeout", to, 0);
    check_eq("t6_done", done, 2'b10);
    check_eq("t6_rdata", rdata, 32'hDEADBEEF);
    check_eq("t6_addr", s_addr, 32'h4);
    req_valid = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
